feature_write_sequencer: RTL and testbench

Writeback end of the feature-map addressing scheme. It accepts a stream of output pixels from the compute pipeline and writes them into feature memory as 64x64 word planes. Each plane starts at a base address of the form featureIndex*4096, and up to three planes are written per job, one per base address. It sits between the layer datapath and the feature SRAM write port, and is driven by the same per-opcode base addresses used for fetch.

---
 rtl/feature_write_sequencer.sv | 141 ++++++++++++++
 tb/tb_feature_write_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/feature_write_sequencer.sv
// Writes a pixel stream into feature memory as up to three MAP_DIM x MAP_DIM planes per job.
// Define FWS_RELU_EN to clamp negative pixels to zero at writeback.
module feature_write_sequencer #(
  parameter int DATA_W  = 8,
  parameter int MAP_DIM = 64,
  parameter int ADDR_W  = 19
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [1:0]        i_numMaps,
  input  logic [ADDR_W-1:0] i_baseAddr0,
  input  logic [ADDR_W-1:0] i_baseAddr1,
  input  logic [ADDR_W-1:0] i_baseAddr2,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic              o_wrEn,
  output logic [ADDR_W-1:0] o_wrAddr,
  output logic [DATA_W-1:0] o_wrData,
  output logic              o_busy,
  output logic              o_done
);

  localparam int PIX_W = $clog2(MAP_DIM * MAP_DIM);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(MAP_DIM * MAP_DIM - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [PIX_W-1:0]    pix_q, pix_d;
  logic [1:0]          map_q, map_d;
  logic [1:0]          num_q, num_d;
  logic [ADDR_W-1:0]   base0_q, base0_d;
  logic [ADDR_W-1:0]   base1_q, base1_d;
  logic [ADDR_W-1:0]   base2_q, base2_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;

  logic                accept;
  logic [ADDR_W-1:0]   cur_base;
  logic [DATA_W-1:0]   wb_data;

  assign accept = (state_q == S_WRITE) && i_valid;

  always_comb begin
    case (map_q)
      2'd1:    cur_base = base1_q;
      2'd2:    cur_base = base2_q;
      default: cur_base = base0_q;
    endcase
  end

`ifdef FWS_RELU_EN
  assign wb_data = i_data[DATA_W-1] ? '0 : i_data;
`else
  assign wb_data = i_data;
`endif

  always_comb begin
    // NOTE: every target gets a default before the case so no path can infer a latch.
    state_d   = state_q;
    pix_d     = pix_q;
    map_d     = map_q;
    num_d     = num_q;
    base0_d   = base0_q;
    base1_d   = base1_q;
    base2_d   = base2_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          num_d   = i_numMaps;
          base0_d = i_baseAddr0;
          base1_d = i_baseAddr1;
          base2_d = i_baseAddr2;
          pix_d   = '0;
          map_d   = '0;
          state_d = (i_numMaps == 2'd0) ? S_DONE : S_WRITE;
        end
      end
      S_WRITE: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cur_base + ADDR_W'(pix_q);
          wr_data_d = wb_data;
          pix_d     = pix_q + PIX_W'(1);
          if (pix_q == PIX_LAST) begin
            map_d = map_q + 2'd1;
            // Last pixel of the last plane: its write lands in the DONE cycle.
            if ((map_q + 2'd1) == num_q) state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      pix_q     <= '0;
      map_q     <= '0;
      num_q     <= '0;
      base0_q   <= '0;
      base1_q   <= '0;
      base2_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      pix_q     <= pix_d;
      map_q     <= map_d;
      num_q     <= num_d;
      base0_q   <= base0_d;
      base1_q   <= base1_d;
      base2_q   <= base2_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign o_ready  = (state_q == S_WRITE);
  assign o_busy   = (state_q != S_IDLE);
  assign o_done   = (state_q == S_DONE);
  assign o_wrEn   = wr_en_q;
  assign o_wrAddr = wr_addr_q;
  assign o_wrData = wr_data_q;

endmodule

// File: tb/tb_feature_write_sequencer.sv
// Bench for feature_write_sequencer: job-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_feature_write_sequencer;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 19;
  localparam int PLANE  = 4096;

  logic              clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_start = 1'b0;
  logic [1:0]        i_numMaps = '0;
  logic [ADDR_W-1:0] i_baseAddr0 = '0;
  logic [ADDR_W-1:0] i_baseAddr1 = '0;
  logic [ADDR_W-1:0] i_baseAddr2 = '0;
  logic              i_valid = 1'b0;
  logic [DATA_W-1:0] i_data = '0;
  logic              o_ready, o_wrEn, o_busy, o_done;
  logic [ADDR_W-1:0] o_wrAddr;
  logic [DATA_W-1:0] o_wrData;

  always #5 clk = ~clk;

  feature_write_sequencer dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_numMaps(i_numMaps),
    .i_baseAddr0(i_baseAddr0), .i_baseAddr1(i_baseAddr1), .i_baseAddr2(i_baseAddr2),
    .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready), .o_wrEn(o_wrEn),
    .o_wrAddr(o_wrAddr), .o_wrData(o_wrData), .o_busy(o_busy), .o_done(o_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] wb(input logic [DATA_W-1:0] d);
`ifdef FWS_RELU_EN
    return d[DATA_W-1] ? '0 : d;
`else
    return d;
`endif
  endfunction

  // Job-level model: phase 0 idle, 1 writing, 2 done; m_k counts pixels accepted in the job.
  int                m_phase = 0;
  int                m_k = 0;
  int                m_num = 0;
  int                m_base[3];
  logic              ex_en = 1'b0;
  logic [ADDR_W-1:0] ex_addr = '0;
  logic [DATA_W-1:0] ex_data = '0;

  always @(posedge clk) begin
    ex_en = 1'b0;
    if (i_rst) begin
      m_phase = 0;
      m_k     = 0;
    end else begin
      case (m_phase)
        0: if (i_start) begin
          m_num     = int'(i_numMaps);
          m_base[0] = int'(i_baseAddr0);
          m_base[1] = int'(i_baseAddr1);
          m_base[2] = int'(i_baseAddr2);
          m_k       = 0;
          m_phase   = (m_num == 0) ? 2 : 1;
        end
        1: if (i_valid) begin
          ex_en   = 1'b1;
          ex_addr = ADDR_W'((m_base[m_k / PLANE] + (m_k % PLANE)) % (1 << ADDR_W));
          ex_data = wb(i_data);
          m_k++;
          if (m_k == m_num * PLANE) m_phase = 2;
        end
        default: m_phase = 0;
      endcase
    end
  end

  // Per-cycle compare plus a log of everything written.
  bit                cmp_en = 1'b0;
  logic [ADDR_W-1:0] a_log[$];
  logic [DATA_W-1:0] d_log[$];
  int                done_cnt = 0;
  logic              done_en = 1'b0;
  logic [ADDR_W-1:0] done_addr = '0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("ready", 32'(o_ready), 32'(m_phase == 1));
      check("busy",  32'(o_busy),  32'(m_phase != 0));
      check("done",  32'(o_done),  32'(m_phase == 2));
      check("wr_en", 32'(o_wrEn),  32'(ex_en));
      if (ex_en) begin
        check("wr_addr", 32'(o_wrAddr), 32'(ex_addr));
        check("wr_data", 32'(o_wrData), 32'(ex_data));
      end
      if (o_wrEn) begin
        a_log.push_back(o_wrAddr);
        d_log.push_back(o_wrData);
      end
      if (o_done) begin
        done_cnt++;
        done_en   = o_wrEn;
        done_addr = o_wrAddr;
      end
    end
  end

  // All drive tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [1:0] num, input int b0, input int b1, input int b2);
    i_start     = 1'b1;
    i_numMaps   = num;
    i_baseAddr0 = ADDR_W'(b0);
    i_baseAddr1 = ADDR_W'(b1);
    i_baseAddr2 = ADDR_W'(b2);
    @(posedge clk);
    #1;
    i_start     = 1'b0;
    i_numMaps   = 2'd3;
    i_baseAddr0 = 19'h5A5A5;
    i_baseAddr1 = 19'h12345;
    i_baseAddr2 = 19'h7FFFF;
  endtask

  task automatic stream(input int n, input bit gappy);
    int   acc = 0;
    int   cyc = 0;
    logic rdy;
    while (acc < n && cyc < 30000) begin
      i_valid = gappy ? (((cyc * 7 + 3) % 5) < 3) : 1'b1;
      i_data  = (acc == 0) ? 8'h85 : (acc == 1) ? 8'h12 : DATA_W'(acc * 37 + cyc);
      @(negedge clk);
      rdy = o_ready;
      @(posedge clk);
      if (i_valid && rdy) acc++;
      cyc++;
      #1;
    end
    i_valid = 1'b0;
    checks++;
    if (acc < n) begin
      errors++;
      $display("FAIL stream_timeout: accepted %0d required %0d", acc, n);
    end
  endtask

  task automatic clear_log();
    a_log.delete();
    d_log.delete();
  endtask

  initial begin
    int d0;
    int bad;
    int acc_before;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(o_ready), 0);
    check("rst_wr_en", 32'(o_wrEn), 0);
    check("rst_addr",  32'(o_wrAddr), 0);
    check("rst_data",  32'(o_wrData), 0);
    check("rst_busy",  32'(o_busy), 0);
    check("rst_done",  32'(o_done), 0);
    i_rst  = 1'b0;
    cmp_en = 1'b1;
    idle(2);

    // 1: one plane at 12288, back-to-back
    clear_log();
    d0 = done_cnt;
    start_job(2'd1, 12288, 0, 0);
    stream(4096, 1'b0);
    check("t1_done_now", 32'(o_done), 1);
    check("t1_done_wr", 32'(o_wrEn), 1);
    check("t1_done_addr", 32'(o_wrAddr), 16383);
    idle(1);
    check("t1_busy_drop", 32'(o_busy), 0);
    idle(2);
    check("t1_writes", 32'(a_log.size()), 4096);
    check("t1_first", 32'(a_log[0]), 12288);
    check("t1_last", 32'(a_log[a_log.size() - 1]), 16383);
    check("t1_done_cnt", 32'(done_cnt - d0), 1);

    // 2: three planes, contiguous; a start pulse mid-job must be ignored
    clear_log();
    d0 = done_cnt;
    start_job(2'd3, 0, 4096, 8192);
    stream(5000, 1'b0);
    start_job(2'd1, 100000, 0, 0);
    stream(12288 - 5000, 1'b0);
    idle(3);
    check("t2_writes", 32'(a_log.size()), 12288);
    bad = 0;
    foreach (a_log[i]) if (a_log[i] !== ADDR_W'(i)) bad++;
    check("t2_contig_bad", 32'(bad), 0);
    check("t2_done_cnt", 32'(done_cnt - d0), 1);
    check("t2_done_addr", 32'(done_addr), 12287);
    check("t2_done_wr", 32'(done_en), 1);

    // 3: gappy valid; writes must equal acceptances with no gaps
    clear_log();
    d0 = done_cnt;
    acc_before = m_k;
    start_job(2'd1, 20480, 0, 0);
    stream(4096, 1'b1);
    idle(3);
    check("t3_writes", 32'(a_log.size()), 4096);
    bad = 0;
    foreach (a_log[i]) if (a_log[i] !== ADDR_W'(20480 + i)) bad++;
    check("t3_contig_bad", 32'(bad), 0);
    check("t3_done_cnt", 32'(done_cnt - d0), 1);

    // 4: zero planes
    clear_log();
    d0 = done_cnt;
    start_job(2'd0, 0, 0, 0);
    check("t4_done", 32'(o_done), 1);
    check("t4_busy", 32'(o_busy), 1);
    check("t4_wr_en", 32'(o_wrEn), 0);
    idle(1);
    check("t4_done_off", 32'(o_done), 0);
    check("t4_busy_off", 32'(o_busy), 0);
    idle(2);
    check("t4_writes", 32'(a_log.size()), 0);
    check("t4_done_cnt", 32'(done_cnt - d0), 1);

    // 5: reset after 100 accepted pixels
    clear_log();
    d0 = done_cnt;
    start_job(2'd1, 0, 0, 0);
    stream(100, 1'b0);
    i_valid = 1'b1;
    i_rst   = 1'b1;
    @(posedge clk);
    #1;
    i_rst   = 1'b0;
    i_valid = 1'b0;
    check("t5_wr_en", 32'(o_wrEn), 0);
    check("t5_busy", 32'(o_busy), 0);
    check("t5_ready", 32'(o_ready), 0);
    check("t5_addr", 32'(o_wrAddr), 0);
    idle(5);
    check("t5_writes", 32'(a_log.size()), 100);
    check("t5_no_done", 32'(done_cnt - d0), 0);

    // 6: fresh job at 270336; first pixels 0x85 then 0x12
    clear_log();
    d0 = done_cnt;
    start_job(2'd1, 270336, 0, 0);
    stream(2, 1'b0);
    idle(2);
    check("t6_addr0", 32'(a_log[0]), 270336);
    check("t6_addr1", 32'(a_log[1]), 270337);
`ifdef FWS_RELU_EN
    check("t6_data0", 32'(d_log[0]), 32'h00);
`else
    check("t6_data0", 32'(d_log[0]), 32'h85);
`endif
    check("t6_data1", 32'(d_log[1]), 32'h12);
    stream(4094, 1'b1);
    idle(3);
    check("t6_writes", 32'(a_log.size()), 4096);
    check("t6_last", 32'(a_log[a_log.size() - 1]), 270336 + 4095);
    check("t6_done_cnt", 32'(done_cnt - d0), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
